// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
// Odd-parity helper is used by the frame checker.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_rx_state_t;

    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FILTER_LEN = 8;

    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_frame_if.sv
// Receiver output bundle: byte strobe feeding the RX FIFO write port plus status.
// No backpressure: the consumer must take every rx_valid.
interface ps2_rx_frame_if;
    import ps2_pkg::*;

    logic [PS2_DATA_BITS-1:0] rx_data;
    logic                     rx_valid;
    logic                     parity_error;
    logic                     frame_error;
    logic                     busy;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_error,
        output frame_error,
        output busy
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input parity_error,
        input frame_error,
        input busy
    );

endinterface

// File: rtl/ps2_input_filter.sv
// 2-flop synchronizer + glitch filter + falling-edge pulse for the PS/2 clock pin.
// fall is a registered 1-cycle pulse FILTER_LEN+2 cycles after a clean pin transition.
module ps2_input_filter import ps2_pkg::*; #(
    parameter int FILTER_LEN = PS2_FILTER_LEN
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // The counter only runs while the sample disagrees with the filtered level,
    // so any glitch shorter than FILTER_LEN cycles is forgotten.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            fall  <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= sync2;
                cnt   <= '0;
                fall  <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: start, 8 data LSB-first, odd parity, stop.
// Strobes are registered, FILTER_LEN+3 cycles after the stop-bit pin edge; no backpressure.
module ps2_rx_frame import ps2_pkg::*; #(
    parameter int FILTER_LEN     = PS2_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           enable,
    input  logic           ps2_clk_in,
    input  logic           ps2_data_in,
    ps2_rx_frame_if.master rx
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(PS2_DATA_BITS);

    logic                     fall;
    logic                     data_s1;
    logic                     data_s2;
    ps2_rx_state_t            state;
    logic [BW-1:0]            bit_cnt;
    logic [PS2_DATA_BITS-1:0] shift;
    logic [PS2_DATA_BITS-1:0] data_q;
    logic                     par_bit;
    logic [TW-1:0]            tcnt;
    logic                     valid_q;
    logic                     perr_q;
    logic                     ferr_q;
    logic                     busy_q;

    ps2_input_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (ps2_clk_in),
        .fall    (fall)
    );

    // Data only needs to be stable around the filtered falling edge, so no filter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            data_s1 <= ps2_data_in;
            data_s2 <= data_s1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            data_q  <= '0;
            par_bit <= 1'b0;
            tcnt    <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            if (!enable) begin
                state   <= IDLE;
                busy_q  <= 1'b0;
                bit_cnt <= '0;
                tcnt    <= '0;
            end else if (fall) begin
                // A fall always clears the watchdog, so it beats a coincident timeout.
                tcnt <= '0;
                case (state)
                    IDLE: begin
                        if (!data_s2) begin
                            state   <= DATA;
                            busy_q  <= 1'b1;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift   <= {data_s2, shift[PS2_DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BW'(PS2_DATA_BITS - 1)) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= data_s2;
                        state   <= STOP;
                    end
                    STOP: begin
                        if (!data_s2) begin
                            ferr_q <= 1'b1;
                        end else if (odd_parity_ok(shift, par_bit)) begin
                            data_q  <= shift;
                            valid_q <= 1'b1;
                        end else begin
                            perr_q <= 1'b1;
                        end
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end else if (state != IDLE) begin
                // Strobe lands TIMEOUT_CYCLES+1 cycles after the last fall.
                if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    ferr_q <= 1'b1;
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    tcnt   <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end else begin
                tcnt <= '0;
            end
        end
    end

    assign rx.rx_data      = data_q;
    assign rx.rx_valid     = valid_q;
    assign rx.parity_error = perr_q;
    assign rx.frame_error  = ferr_q;
    assign rx.busy         = busy_q;

endmodule

// File: doc/ps2_rx_frame.md
# ps2_rx_frame

PS/2 device-to-host frame receiver. It synchronizes and filters the raw `ps2_clk_in` / `ps2_data_in` lines, deserializes the 11-bit PS/2 frame (start, 8 data LSB-first, odd parity, stop) and checks it. Each good byte is delivered as a single-cycle strobe that drives the PS/2 RX FIFO write port directly: `rx_valid` goes to `fifo_write` and `rx_data` goes to `fifo_data_in`.

## Interface
Parameters:
- `FILTER_LEN`, default 8: number of consecutive identical synchronized samples required before the filtered PS/2 clock changes level.
- `TIMEOUT_CYCLES`, default 200000: `clk` cycles allowed between consecutive filtered PS/2 clock falling edges inside a frame (2 ms at 100 MHz).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  receiver enable; low forces IDLE.
- `ps2_clk_in`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data_in`  in  1  raw PS/2 data pin, asynchronous.
- `rx_data`  out  8  last good byte; held until the next good frame.
- `rx_valid`  out  1  one-cycle strobe when a good frame completes.
- `parity_error`  out  1  one-cycle strobe on a parity failure.
- `frame_error`  out  1  one-cycle strobe on a bad stop bit or a timeout.
- `busy`  out  1  high while a frame is in progress (state not IDLE).

## Operation
- Reset values: `rx_data`=0x00; `rx_valid`, `parity_error`, `frame_error`, `busy` = 0; state IDLE; filtered clock = 1; all counters 0.
- Input path: both pins pass through a 2-flop synchronizer.
  - Synchronized clock then goes through the glitch filter. The filter counter counts cycles in which the sample differs from the filtered level and resets on any match. At `FILTER_LEN` the filtered level flips.
  - `fall` is a 1-cycle pulse on filtered 1→0. Data is sampled from the synchronized data line in the `fall` cycle.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions occur only on `fall` unless stated.
  - IDLE: sampled 0 → DATA, bit count cleared. Sampled 1 → stay in IDLE, no error.
  - DATA: shift the bit in LSB-first (shift right, insert at bit 7). After the 8th bit → PARITY. The 3-bit counter wraps 7→0.
  - PARITY: store the bit → STOP.
  - STOP: outcome depends on the stop bit and parity.
    - Stop = 1 and odd parity over data+parity holds: `rx_data` ← shift register, `rx_valid`=1 for one cycle.
    - Stop = 1 and parity fails: `parity_error`=1, `rx_data` unchanged.
    - Stop = 0: `frame_error`=1, regardless of parity.
    - Always → IDLE.
- Timeout: the counter clears on every `fall` and in IDLE, and increments otherwise. On reaching `TIMEOUT_CYCLES` while not IDLE: `frame_error`=1 for one cycle → IDLE.
  - Timeout and `fall` in the same cycle: `fall` wins, because the counter clears.
- `enable` low: state forced to IDLE, no strobes, partial frame discarded silently. The filter keeps running.
- At most one of `rx_valid` / `parity_error` / `frame_error` is high in any cycle.
- Reset mid-frame: everything returns to reset values immediately; no strobe is emitted.
- No backpressure. The downstream FIFO must accept every `rx_valid`. The minimum spacing of strobes is one PS/2 frame (≫ 1 cycle).

## Timing
- Pin-to-`fall` latency: `FILTER_LEN`+2 `clk` cycles after a clean pin transition (2 synchronizer flops + filter count).
- `rx_valid` / error strobes are registered: high in the cycle after the `fall` that samples the stop bit. Total pin-to-strobe latency is `FILTER_LEN`+3 cycles.
- `rx_data` updates in the same cycle `rx_valid` rises, and is stable afterwards.
- `busy` rises the cycle after the start-bit `fall`. It falls in the cycle the strobe is asserted.
- Timeout strobe: `TIMEOUT_CYCLES`+1 cycles after the last `fall`.

## Structure
- Shared package `ps2_pkg`: state enum typedef `ps2_rx_state_t` {IDLE, DATA, PARITY, STOP}, constant `PS2_DATA_BITS`=8, default `PS2_FILTER_LEN`.
- Sub-module `ps2_input_filter`: synchronizer + glitch filter + falling-edge pulse, parameterized by `FILTER_LEN`.
  - Instantiated for `ps2_clk_in`.
  - Data uses a plain 2-flop synchronizer.
- FSM, shift register, bit counter, parity and timeout logic sit in `ps2_rx_frame`.

## Test plan
- Frame 0x1C, parity 0, stop 1, 12.5 kHz PS/2 clock → exactly one `rx_valid`, `rx_data`=0x1C, `FILTER_LEN`+3 cycles after the stop-bit falling edge.
- Back-to-back frames 0xF0 (parity 1), 0x1C (parity 0) into a `PS2_FIFO` instance → FIFO count 2, reads yield 0xF0 then 0x1C.
- Frame 0x1C with parity 1 → `parity_error` pulse, no `rx_valid`, `rx_data` keeps its previous value.
- Frame 0xAA with stop 0 → `frame_error` pulse. Frame stalls after 5 data bits → `frame_error` at `TIMEOUT_CYCLES`+1, `busy` low. A following 0xAA frame (parity 1) → received correctly.
- 3-cycle low glitch on `ps2_clk_in` (`FILTER_LEN`=8), both idle and mid-bit → no `fall`, no state change; subsequent frame 0x55 received correctly.
- `reset_n` pulsed low after 4 data bits, and `enable` dropped mid-frame → no strobes, outputs at reset values, next frame 0x12 received correctly.
